// File: rtl/shift_chain_pkg.sv
// Shared types and helpers for the parametrised shift_chain delay line.
package shift_chain_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_chain_stage.sv
// One register stage of shift_chain: serial/load next-value mux with optional
// inversion on the serial path only.
module chain_stage #(
    parameter int              WIDTH   = 8,
    parameter bit              INV     = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sel_load,
    input  logic [WIDTH-1:0] ser_in,
    input  logic [WIDTH-1:0] load_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] q_r;

    // Select the candidate next value; loaded data bypasses the inversion.
    always_comb begin
        next_s = q_r;
        if (sel_load) begin
            next_s = load_in;
        end else if (INV) begin
            next_s = ~ser_in;
        end else begin
            next_s = ser_in;
        end
    end

    // Stage register; reset dominates the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= RST_VAL;
        end else if (en) begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/shift_chain.sv
// Configurable register chain with shift, parallel load, rotate, tap select
// and fill tracking; used as a delay line between datapath blocks.
module shift_chain
    import shift_chain_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [DEPTH-1:0] INV_MASK = DEPTH'(4'b0010),
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic [DEPTH*WIDTH-1:0]       load_data,
    input  logic [$clog2(DEPTH)-1:0]     tap_sel,
    output logic [DEPTH*WIDTH-1:0]       q_stages,
    output logic [WIDTH-1:0]             q_out,
    output logic [WIDTH-1:0]             tap_out,
    output logic [cnt_width(DEPTH)-1:0]  valid_cnt,
    output logic                         full
);

    localparam int CW = cnt_width(DEPTH);

    mode_e            mode_s;
    logic             stage_en_s;
    logic             sel_load_s;
    logic [WIDTH-1:0] stage_q_s  [DEPTH];
    logic [WIDTH-1:0] stage_in_s [DEPTH];
    logic [CW-1:0]    valid_cnt_r;
    logic [CW-1:0]    valid_nxt_s;

    assign mode_s     = mode_e'(mode);
    assign stage_en_s = en && (mode_s != MODE_HOLD);
    assign sel_load_s = (mode_s == MODE_LOAD);

    // Serial input of each stage; stage 0 closes the ring only in ROTATE.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_in_s[i] = {WIDTH{1'b0}};
        end
        if (mode_s == MODE_ROTATE) begin
            stage_in_s[0] = stage_q_s[DEPTH-1];
        end else begin
            stage_in_s[0] = d;
        end
        for (int i = 1; i < DEPTH; i++) begin
            stage_in_s[i] = stage_q_s[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        chain_stage #(
            .WIDTH   (WIDTH),
            .INV     (INV_MASK[g]),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .en       (stage_en_s),
            .sel_load (sel_load_s),
            .ser_in   (stage_in_s[g]),
            .load_in  (load_data[g*WIDTH +: WIDTH]),
            .q        (stage_q_s[g])
        );
        assign q_stages[g*WIDTH +: WIDTH] = stage_q_s[g];
    end

    // Fill count: saturating on SHIFT, full on LOAD, untouched otherwise.
    always_comb begin
        valid_nxt_s = valid_cnt_r;
        if (en) begin
            case (mode_s)
                MODE_SHIFT: begin
                    if (valid_cnt_r != CW'(DEPTH)) begin
                        valid_nxt_s = valid_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        valid_nxt_s = valid_cnt_r;
                    end
                end
                MODE_LOAD: valid_nxt_s = CW'(DEPTH);
                default:   valid_nxt_s = valid_cnt_r;
            endcase
        end else begin
            valid_nxt_s = valid_cnt_r;
        end
    end

    // Fill count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_cnt_r <= {CW{1'b0}};
        end else begin
            valid_cnt_r <= valid_nxt_s;
        end
    end

    // Tap mux; indices past the last stage read as zero.
    always_comb begin
        tap_out = {WIDTH{1'b0}};
        if (32'(tap_sel) < DEPTH) begin
            tap_out = stage_q_s[tap_sel];
        end else begin
            tap_out = {WIDTH{1'b0}};
        end
    end

    assign q_out     = stage_q_s[DEPTH-1];
    assign valid_cnt = valid_cnt_r;
    assign full      = (valid_cnt_r == CW'(DEPTH));

endmodule

// File: tb/tb_shift_chain.sv
// Directed self-checking bench for shift_chain (WIDTH=8, DEPTH=4, INV_MASK=4'b0010).
module tb_shift_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  d;
    logic [31:0] load_data;
    logic [1:0]  tap_sel;
    logic [31:0] q_stages;
    logic [7:0]  q_out;
    logic [7:0]  tap_out;
    logic [2:0]  valid_cnt;
    logic        full;

    int vectors    = 0;
    int miscompares = 0;

    shift_chain #(
        .WIDTH    (8),
        .DEPTH    (4),
        .INV_MASK (4'b0010),
        .RST_VAL  (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .load_data (load_data),
        .tap_sel   (tap_sel),
        .q_stages  (q_stages),
        .q_out     (q_out),
        .tap_out   (tap_out),
        .valid_cnt (valid_cnt),
        .full      (full)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; mode = 2'b01; d = 8'hFF;
        load_data = 32'h0; tap_sel = 2'd0;
        step();
        step();
        reset = 1'b0; mode = 2'b00;
        vectors++;
        if (q_stages !== 32'h00000000) begin
            miscompares++;
            $display("FAIL reset_stages: got %h want %h", q_stages, 32'h0);
        end
        vectors++;
        if (valid_cnt !== 3'd0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cnt: got cnt=%0d full=%b want cnt=0 full=0", valid_cnt, full);
        end
    endtask

    task automatic test_shift();
        logic [31:0] exp_st [5];
        logic [2:0]  exp_cnt [5];
        exp_st[0] = 32'h0000FFA5; exp_cnt[0] = 3'd1;
        exp_st[1] = 32'h00FF5A00; exp_cnt[1] = 3'd2;
        exp_st[2] = 32'hFF5AFF00; exp_cnt[2] = 3'd3;
        exp_st[3] = 32'h5AFFFF00; exp_cnt[3] = 3'd4;
        exp_st[4] = 32'hFFFFFF00; exp_cnt[4] = 3'd4;
        en = 1'b1; mode = 2'b01; d = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            step();
            d = 8'h00;
            vectors++;
            if (q_stages !== exp_st[i]) begin
                miscompares++;
                $display("FAIL shift_stages[%0d]: got %h want %h", i, q_stages, exp_st[i]);
            end
            vectors++;
            if (valid_cnt !== exp_cnt[i] || full !== (i >= 3)) begin
                miscompares++;
                $display("FAIL shift_cnt[%0d]: got cnt=%0d full=%b want cnt=%0d full=%b",
                         i, valid_cnt, full, exp_cnt[i], (i >= 3));
            end
            if (i == 3) begin
                vectors++;
                if (q_out !== 8'h5A) begin
                    miscompares++;
                    $display("FAIL shift_latency: q_out got %h want 5a", q_out);
                end
            end
        end
    endtask

    task automatic test_load_rotate();
        en = 1'b1; mode = 2'b10; load_data = 32'h44332211;
        step();
        vectors++;
        if (q_stages !== 32'h44332211 || valid_cnt !== 3'd4) begin
            miscompares++;
            $display("FAIL load: got %h cnt=%0d want 44332211 cnt=4", q_stages, valid_cnt);
        end
        mode = 2'b11;
        step();
        vectors++;
        if (q_stages !== 32'h3322EE44 || valid_cnt !== 3'd4) begin
            miscompares++;
            $display("FAIL rotate: got %h cnt=%0d want 3322ee44 cnt=4", q_stages, valid_cnt);
        end
    endtask

    task automatic test_tap();
        logic [7:0] exp_tap [4];
        exp_tap[0] = 8'h11; exp_tap[1] = 8'h22; exp_tap[2] = 8'h33; exp_tap[3] = 8'h44;
        en = 1'b1; mode = 2'b10; load_data = 32'h44332211;
        step();
        mode = 2'b00; d = 8'hC3;
        step();
        vectors++;
        if (q_stages !== 32'h44332211) begin
            miscompares++;
            $display("FAIL hold: got %h want 44332211", q_stages);
        end
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            vectors++;
            if (tap_out !== exp_tap[i]) begin
                miscompares++;
                $display("FAIL tap[%0d]: got %h want %h", i, tap_out, exp_tap[i]);
            end
        end
    endtask

    task automatic test_enable();
        en = 1'b0; mode = 2'b01; d = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (q_stages !== 32'h44332211 || valid_cnt !== 3'd4) begin
                miscompares++;
                $display("FAIL en_hold[%0d]: got %h cnt=%0d want 44332211 cnt=4", i, q_stages, valid_cnt);
            end
        end
        en = 1'b1;
        step();
        vectors++;
        if (q_stages !== 32'h3322EE0F) begin
            miscompares++;
            $display("FAIL en_shift: got %h want 3322ee0f", q_stages);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; step(); reset = 1'b0;
        en = 1'b1; mode = 2'b01; d = 8'h12;
        step();
        step();
        vectors++;
        if (valid_cnt !== 3'd2) begin
            miscompares++;
            $display("FAIL mid_precnt: got %0d want 2", valid_cnt);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (q_stages !== 32'h0 || valid_cnt !== 3'd0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got %h cnt=%0d full=%b want 0 cnt=0 full=0", q_stages, valid_cnt, full);
        end
        step();
        vectors++;
        if (q_stages !== 32'h0000FF12 || valid_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL mid_restart: got %h cnt=%0d want 0000ff12 cnt=1", q_stages, valid_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_load_rotate();
        test_tap();
        test_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
